uart_tx_ctrl: RTL

//  UART transmitter: serialises one byte per request as 8N1 (optionally 8N2), LSB first, onto TXD.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_ctrl_if.sv | 27 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, data width and bit-period helper.
// Used by the transmit controller and the receive path.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    function automatic int bit_clks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-request handshake between user logic and the UART transmitter.
// The master requests frames; the slave drives the line and status.
interface uart_tx_ctrl_if;

    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       TXD;
    logic       TX_BUSY;
    logic       TX_DONE;

    modport master (
        output TX_START,
        output TX_DATA,
        input  TXD,
        input  TX_BUSY,
        input  TX_DONE
    );

    modport slave (
        input  TX_START,
        input  TX_DATA,
        output TXD,
        output TX_BUSY,
        output TX_DONE
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BIT_CLKS-1 while enabled, bit_end on the last count.
// Clear has priority and holds the count at zero.
module uart_bit_timer #(
    parameter int BIT_CLKS = 868
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int TW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [TW-1:0] cnt;

    assign bit_end = en && (cnt == TW'(BIT_CLKS - 1));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: one byte per request, 8N1 or 8N2, LSB first.
// All outputs are registered from the next-state values.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int STOP_BITS = 1
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_ctrl_if.slave tx
);

    localparam int BIT_CLKS = bit_clks(CLK_FREQ, BAUD_RATE);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    state_t                 state;
    state_t                 state_n;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   shift_n;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_idx_n;
    logic                   stop_cnt;
    logic                   stop_cnt_n;
    logic                   bit_end;
    logic                   accept;
    logic                   last_bit;
    logic                   last_stop;
    logic                   txd_n;
    logic                   busy_n;
    logic                   done_n;
    logic                   txd_q;
    logic                   busy_q;
    logic                   done_q;

    assign accept    = (state == IDLE) && tx.TX_START;
    assign last_bit  = (bit_idx == 3'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    uart_bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state == IDLE),
        .en      (1'b1),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = bit_end ? DATA : START;
            DATA:    state_n = (bit_end && last_bit) ? STOP : DATA;
            STOP:    state_n = (bit_end && last_stop) ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // Datapath next values; the line is driven from the post-edge shift value.
    always_comb begin
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        case (state)
            IDLE: begin
                bit_idx_n  = '0;
                stop_cnt_n = 1'b0;
                if (accept) shift_n = tx.TX_DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) stop_cnt_n = stop_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        txd_n  = 1'b1;
        busy_n = (state_n != IDLE);
        done_n = (state == STOP) && (state_n == IDLE);
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            txd_q    <= txd_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign tx.TXD     = txd_q;
    assign tx.TX_BUSY = busy_q;
    assign tx.TX_DONE = done_q;

endmodule
